// File: rtl/alu_power_management.sv
// ALU with S3 operand save and hold control, plus a power-management sequencer.
// The sequencer asserts gate/clamp/reset/power-off in order and releases them in reverse.

module alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] opcode,
    input  logic       s3_state,
    input  logic       idle,
    input  logic       interrupt,
    output logic [3:0] result,
    output logic [3:0] saved_a,
    output logic [3:0] saved_b,
    output logic [1:0] saved_opcode
);
    logic [3:0] result_q, result_d;
    logic [3:0] saved_a_q, saved_a_d;
    logic [3:0] saved_b_q, saved_b_d;
    logic [1:0] saved_opcode_q, saved_opcode_d;

    // Next result only when not saving or held; S3 save captures operands every edge.
    always_comb begin
        result_d       = result_q;
        saved_a_d      = saved_a_q;
        saved_b_d      = saved_b_q;
        saved_opcode_d = saved_opcode_q;
        if (!s3_state && !idle && !interrupt) begin
            case (opcode)
                2'b00:   result_d = a + b;
                2'b01:   result_d = a - b;
                2'b10:   result_d = a & b;
                default: result_d = a | b;
            endcase
        end
        if (s3_state) begin
            saved_a_d      = a;
            saved_b_d      = b;
            saved_opcode_d = opcode;
        end
    end

    // Register stage with synchronous reset overriding all controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q       <= '0;
            saved_a_q      <= '0;
            saved_b_q      <= '0;
            saved_opcode_q <= '0;
        end else begin
            result_q       <= result_d;
            saved_a_q      <= saved_a_d;
            saved_b_q      <= saved_b_d;
            saved_opcode_q <= saved_opcode_d;
        end
    end

    assign result       = result_q;
    assign saved_a      = saved_a_q;
    assign saved_b      = saved_b_q;
    assign saved_opcode = saved_opcode_q;
endmodule

module power_management (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic interrupt,
    output logic clk_gate,
    output logic iso_clampn_deassert,
    output logic reset_assert,
    output logic pg_down
);
    typedef enum logic [2:0] {
        ACTIVE,
        GATED,
        ISO,
        RST,
        PD,
        WAKE1,
        WAKE2,
        WAKE3
    } state_t;

    state_t state_q, state_d;

    // Next-state: entry and wake sequences run to completion once started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE:  if (idle) state_d = GATED;
            GATED: begin
                if (!idle)          state_d = ACTIVE;
                else if (interrupt) state_d = ISO;
            end
            ISO:     state_d = RST;
            RST:     state_d = PD;
            PD:      if (!idle) state_d = WAKE1;
            WAKE1:   state_d = WAKE2;
            WAKE2:   state_d = WAKE3;
            WAKE3:   state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    // State register with synchronous reset to ACTIVE.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ACTIVE;
        else       state_q <= state_d;
    end

    // Moore output decode from the registered state only.
    always_comb begin
        clk_gate            = 1'b0;
        iso_clampn_deassert = 1'b0;
        reset_assert        = 1'b0;
        pg_down             = 1'b0;
        case (state_q)
            GATED, WAKE3: clk_gate = 1'b1;
            ISO, WAKE2: begin
                clk_gate            = 1'b1;
                iso_clampn_deassert = 1'b1;
            end
            RST, WAKE1: begin
                clk_gate            = 1'b1;
                iso_clampn_deassert = 1'b1;
                reset_assert        = 1'b1;
            end
            PD: begin
                clk_gate            = 1'b1;
                iso_clampn_deassert = 1'b1;
                reset_assert        = 1'b1;
                pg_down             = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module alu_power_management (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] opcode,
    input  logic       s3_state,
    input  logic       idle,
    input  logic       interrupt,
    output logic [3:0] result,
    output logic [3:0] saved_a,
    output logic [3:0] saved_b,
    output logic [1:0] saved_opcode,
    output logic       clk_gate,
    output logic       iso_clampn_deassert,
    output logic       reset_assert,
    output logic       pg_down
);
    alu u_alu (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .opcode       (opcode),
        .s3_state     (s3_state),
        .idle         (idle),
        .interrupt    (interrupt),
        .result       (result),
        .saved_a      (saved_a),
        .saved_b      (saved_b),
        .saved_opcode (saved_opcode)
    );

    power_management u_pm (
        .clk                 (clk),
        .reset               (reset),
        .idle                (idle),
        .interrupt           (interrupt),
        .clk_gate            (clk_gate),
        .iso_clampn_deassert (iso_clampn_deassert),
        .reset_assert        (reset_assert),
        .pg_down             (pg_down)
    );
endmodule

// File: tb/tb_alu_power_management.sv
// Bench for alu_power_management: directed steps followed by random traffic,
// all checked against a behavioural model kept here.

module tb_alu_power_management;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a, b;
    logic [1:0] opcode;
    logic       s3_state, idle, interrupt;
    logic [3:0] result, saved_a, saved_b;
    logic [1:0] saved_opcode;
    logic       clk_gate, iso_clampn_deassert, reset_assert, pg_down;

    int total = 0;
    int bad   = 0;

    // Model state. Power manager modelled as a depth 0..4 of asserted controls
    // (gate, clamp, reset, power-off as a thermometer) plus a waking flag.
    logic [3:0] m_result, m_sa, m_sb;
    logic [1:0] m_sop;
    int         m_depth;
    bit         m_waking;

    always #5 clk = ~clk;

    alu_power_management dut (
        .clk                 (clk),
        .reset               (reset),
        .a                   (a),
        .b                   (b),
        .opcode              (opcode),
        .s3_state            (s3_state),
        .idle                (idle),
        .interrupt           (interrupt),
        .result              (result),
        .saved_a             (saved_a),
        .saved_b             (saved_b),
        .saved_opcode        (saved_opcode),
        .clk_gate            (clk_gate),
        .iso_clampn_deassert (iso_clampn_deassert),
        .reset_assert        (reset_assert),
        .pg_down             (pg_down)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pm_expected();
        logic [3:0] v;
        v[3] = (m_depth > 0);
        v[2] = (m_depth > 1);
        v[1] = (m_depth > 2);
        v[0] = (m_depth > 3);
        return v;
    endfunction

    task automatic model_update();
        int ia, ib;
        if (reset) begin
            m_result = 4'd0; m_sa = 4'd0; m_sb = 4'd0; m_sop = 2'd0;
            m_depth  = 0;    m_waking = 1'b0;
            return;
        end
        ia = int'(a);
        ib = int'(b);
        if (!s3_state && !idle && !interrupt) begin
            case (int'(opcode))
                0:       m_result = 4'((ia + ib) % 16);
                1:       m_result = 4'((ia - ib + 16) % 16);
                2:       m_result = a & b;
                default: m_result = a | b;
            endcase
        end
        if (s3_state) begin
            m_sa = a; m_sb = b; m_sop = opcode;
        end
        if (m_waking) begin
            m_depth--;
            if (m_depth == 0) m_waking = 1'b0;
        end else begin
            case (m_depth)
                0: if (idle) m_depth = 1;
                1: if (!idle) m_depth = 0; else if (interrupt) m_depth = 2;
                2, 3: m_depth++;
                default: if (!idle) begin m_depth = 3; m_waking = 1'b1; end
            endcase
        end
    endtask

    // One clock: update model from current inputs, advance, compare all outputs.
    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        chk({tag, ".result"}, result, m_result);
        chk({tag, ".saved_a"}, saved_a, m_sa);
        chk({tag, ".saved_b"}, saved_b, m_sb);
        chk({tag, ".saved_op"}, {2'b00, saved_opcode}, {2'b00, m_sop});
        chk({tag, ".pm"}, {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, pm_expected());
    endtask

    task automatic drive(input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] op,
                         input logic s3, input logic idl, input logic intr);
        a = ia; b = ib; opcode = op; s3_state = s3; idle = idl; interrupt = intr;
    endtask

    initial begin
        m_result = 4'd0; m_sa = 4'd0; m_sb = 4'd0; m_sop = 2'd0;
        m_depth = 0; m_waking = 1'b0;

        // Reset with noisy controls
        reset = 1'b1;
        drive(4'd5, 4'd6, 2'd0, 1'b1, 1'b1, 1'b1);
        step("rst0");
        step("rst1");
        chk("rst_result", result, 4'd0);
        chk("rst_pm", {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, 4'b0000);
        reset = 1'b0;

        // ALU ops
        drive(4'd4, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0); step("add");  chk("add_4_5", result, 4'd9);
        drive(4'd8, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0); step("sub");  chk("sub_8_3", result, 4'd5);
        drive(4'd2, 4'd6, 2'd2, 1'b0, 1'b0, 1'b0); step("and");  chk("and_2_6", result, 4'd2);
        drive(4'd9, 4'd4, 2'd3, 1'b0, 1'b0, 1'b0); step("or");   chk("or_9_4", result, 4'd13);
        drive(4'd15, 4'd15, 2'd0, 1'b0, 1'b0, 1'b0); step("ovf"); chk("add_15_15", result, 4'd14);
        drive(4'd3, 4'd8, 2'd1, 1'b0, 1'b0, 1'b0); step("wrap"); chk("sub_3_8", result, 4'd11);
        drive(4'd1, 4'd1, 2'd0, 1'b0, 1'b1, 1'b0); step("hold"); chk("idle_hold", result, 4'd11);
        drive(4'd1, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0); step("back");

        // S3 save then retain
        drive(4'd7, 4'd2, 2'd0, 1'b1, 1'b0, 1'b0); step("s3");
        chk("s3_sa", saved_a, 4'd7);
        chk("s3_hold", result, 4'd2);
        drive(4'd12, 4'd9, 2'd3, 1'b0, 1'b0, 1'b0); step("s3off");
        chk("s3_retain", saved_a, 4'd7);

        // Power down: idle for 10 cycles, then interrupt
        reset = 1'b1; drive(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0); step("rst2");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0); step("idle");
        end
        chk("gated", {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, 4'b1000);
        interrupt = 1'b1;
        step("iso"); step("rstst"); step("pd");
        chk("pd", {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, 4'b1111);
        interrupt = 1'b0;
        step("pdhold");

        // Wake sequence
        idle = 1'b0;
        step("w1"); step("w2"); step("w3"); step("w4");
        chk("woke", {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, 4'b0000);
        step("act");

        // Reset from PD, then require new idle for GATED
        idle = 1'b1; interrupt = 1'b1;
        step("g"); step("i"); step("r"); step("p");
        reset = 1'b1; step("rst_pd");
        chk("rst_from_pd", {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, 4'b0000);
        reset = 1'b0; idle = 1'b0; interrupt = 1'b1;
        step("noidle");
        idle = 1'b1; step("regate");

        // Both high in ACTIVE goes through GATED first
        reset = 1'b1; step("rst3"); reset = 1'b0;
        idle = 1'b1; interrupt = 1'b1;
        step("both1");
        chk("both_gated", {clk_gate, iso_clampn_deassert, reset_assert, pg_down}, 4'b1000);
        step("both2");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive(4'($urandom), 4'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) == 0));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
